// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one SLL/SRA/ROR shifter between two requesters.
// Each accepted operation lands in a single result register guarded by valid/ready.
module shift_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [3:0]       req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [3:0]       req1_amt,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  input  logic             resp_ready,
  output logic             busy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic             r_valid;
  logic             r_id;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic             r_last_grant;

  logic             w_can_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_opnd;
  logic [3:0]       w_amt;
  logic [WIDTH-1:0] w_shift;

  // Grant never looks at operand content, only at valids and the last winner.
  assign w_can_accept = !r_valid | resp_ready;
  assign w_gnt0       = req0_valid & (!req1_valid | r_last_grant);
  assign w_gnt1       = req1_valid & (!req0_valid | !r_last_grant);

  assign req0_ready = !rst & w_can_accept & w_gnt0;
  assign req1_ready = !rst & w_can_accept & w_gnt1;

  assign w_acc0   = req0_valid & req0_ready;
  assign w_acc1   = req1_valid & req1_ready;
  assign w_accept = w_acc0 | w_acc1;

  assign w_op   = w_acc1 ? req1_op   : req0_op;
  assign w_opnd = w_acc1 ? req1_data : req0_data;
  assign w_amt  = w_acc1 ? req1_amt  : req0_amt;

  // Four log-shifter stages (1, 2, 4, 8); the reserved op falls through unchanged.
  always_comb begin
    w_shift = w_opnd;
    for (int s = 0; s < 4; s++) begin
      if (w_amt[s]) begin
        unique case (w_op)
          OP_SLL:  w_shift = w_shift << (1 << s);
          OP_SRA:  w_shift = WIDTH'($signed(w_shift) >>> (1 << s));
          OP_ROR:  w_shift = (w_shift >> (1 << s)) | (w_shift << (WIDTH - (1 << s)));
          default: w_shift = w_shift;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_id         <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_id         <= w_acc1;
      r_data       <= w_shift;
      r_err        <= (w_op == OP_RSV);
      r_last_grant <= w_acc1;
    end else if (resp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign resp_valid = r_valid;
  assign resp_id    = r_id;
  assign resp_data  = r_data;
  assign resp_err   = r_err;
  assign busy       = r_valid;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed vector table, hand sequences and a scoreboarded random soak for shift_arbiter.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic        resp_valid, resp_id, resp_err, resp_ready, busy;
  logic [15:0] resp_data;

  shift_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_data(req1_data), .req1_amt(req1_amt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic v0; logic [1:0] op0; logic [15:0] d0; logic [3:0] a0;
    logic v1; logic [1:0] op1; logic [15:0] d1; logic [3:0] a1;
    logic rr;
    logic e_r0; logic e_r1; logic e_v; logic e_id; logic [15:0] e_d; logic e_err;
  } vec_t;

  vec_t vecs[12];

  // requester-hold tracking
  logic        h_p0 = 1'b0, h_p1 = 1'b0;
  logic [1:0]  h_op0, h_op1;
  logic [15:0] h_d0, h_d1;
  logic [3:0]  h_a0, h_a1;

  // soak model state
  logic        m_valid, m_id, m_last;
  logic        s_v0, s_v1, s_rr, s_g0, s_g1, s_ca, s_acc0, s_acc1, s_gen;
  logic [1:0]  s_op0, s_op1;
  logic [15:0] s_d0, s_d1;
  logic [3:0]  s_a0, s_a1;
  logic [16:0] s_exp;
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  function automatic vec_t mk(int v0, int op0, int d0, int a0, int v1, int op1, int d1, int a1,
                              int rr, int r0, int r1, int ev, int eid, int ed, int eerr);
    vec_t v;
    v.v0 = 1'(v0); v.op0 = 2'(op0); v.d0 = 16'(d0); v.a0 = 4'(a0);
    v.v1 = 1'(v1); v.op1 = 2'(op1); v.d1 = 16'(d1); v.a1 = 4'(a1);
    v.rr = 1'(rr); v.e_r0 = 1'(r0); v.e_r1 = 1'(r1);
    v.e_v = 1'(ev); v.e_id = 1'(eid); v.e_d = 16'(ed); v.e_err = 1'(eerr);
    return v;
  endfunction

  // Bit-by-bit reference: {err, data}
  function automatic logic [16:0] ref_f(logic [1:0] op, logic [15:0] d, logic [3:0] a);
    logic [15:0] r;
    int ai;
    ai = int'(a);
    r  = d;
    case (op)
      2'b00: for (int i = 0; i < 16; i++) r[i] = (i >= ai) ? d[i-ai] : 1'b0;
      2'b01: for (int i = 0; i < 16; i++) r[i] = (i + ai <= 15) ? d[i+ai] : d[15];
      2'b10: for (int i = 0; i < 16; i++) r[i] = d[(i+ai)%16];
      default: r = d;
    endcase
    return {(op == 2'b11), r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [1:0] op0, input logic [15:0] d0, input logic [3:0] a0,
                       input logic v1, input logic [1:0] op1, input logic [15:0] d1, input logic [3:0] a1,
                       input logic rr);
    req0_valid = v0; req0_op = op0; req0_data = d0; req0_amt = a0;
    req1_valid = v1; req1_op = op1; req1_data = d1; req1_amt = a1;
    resp_ready = rr;
  endtask

  // Advance one clock; a stalled requester must keep its request intact.
  task automatic tick();
    if (h_p0 && !rst)
      chk("hold0", 32'({req0_valid, req0_op, req0_amt, req0_data}), 32'({1'b1, h_op0, h_a0, h_d0}));
    if (h_p1 && !rst)
      chk("hold1", 32'({req1_valid, req1_op, req1_amt, req1_data}), 32'({1'b1, h_op1, h_a1, h_d1}));
    h_p0 = req0_valid & !req0_ready & !rst;
    h_p1 = req1_valid & !req1_ready & !rst;
    h_op0 = req0_op; h_d0 = req0_data; h_a0 = req0_amt;
    h_op1 = req1_op; h_d1 = req1_data; h_a1 = req1_amt;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.v0, v.op0, v.d0, v.a0, v.v1, v.op1, v.d1, v.a1, v.rr);
    #1;
    chk({tag, ".rdy0"}, 32'(req0_ready), 32'(v.e_r0));
    chk({tag, ".rdy1"}, 32'(req1_ready), 32'(v.e_r1));
    tick();
    chk({tag, ".valid"}, 32'(resp_valid), 32'(v.e_v));
    chk({tag, ".busy"},  32'(busy),       32'(v.e_v));
    chk({tag, ".id"},    32'(resp_id),    32'(v.e_id));
    chk({tag, ".data"},  32'(resp_data),  32'(v.e_d));
    chk({tag, ".err"},   32'(resp_err),   32'(v.e_err));
  endtask

  initial begin
    // contention from reset: 0,1,0,1,0 then basic ops on req0
    vecs[0]  = mk(1,0,'h00F0,4, 1,1,'hF000,4, 1, 1,0, 1,0,'h0F00,0);
    vecs[1]  = mk(1,2,'h00FF,4, 1,1,'hF000,4, 1, 0,1, 1,1,'hFF00,0);
    vecs[2]  = mk(1,2,'h00FF,4, 1,0,'h0003,2, 1, 1,0, 1,0,'hF00F,0);
    vecs[3]  = mk(1,0,'h1111,1, 1,0,'h0003,2, 1, 0,1, 1,1,'h000C,0);
    vecs[4]  = mk(1,0,'h1111,1, 0,0,0,0,      1, 1,0, 1,0,'h2222,0);
    vecs[5]  = mk(1,2,'h1234,4, 0,0,0,0,      1, 1,0, 1,0,'h4123,0);
    vecs[6]  = mk(1,0,'h0001,15, 0,0,0,0,     1, 1,0, 1,0,'h8000,0);
    vecs[7]  = mk(1,1,'h8000,15, 0,0,0,0,     1, 1,0, 1,0,'hFFFF,0);
    vecs[8]  = mk(1,1,'h7FFF,3, 0,0,0,0,      1, 1,0, 1,0,'h0FFF,0);
    vecs[9]  = mk(1,2,'hABCD,0, 0,0,0,0,      1, 1,0, 1,0,'hABCD,0);
    vecs[10] = mk(1,3,'h5555,7, 0,0,0,0,      1, 1,0, 1,0,'h5555,1);
    vecs[11] = mk(0,0,0,0,      0,0,0,0,      1, 0,0, 0,0,'h5555,1);

    drive(0, 2'd0, 16'h0, 4'h0, 0, 2'd0, 16'h0, 4'h0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("reset.valid", 32'(resp_valid), 32'd0);
    chk("reset.busy",  32'(busy),       32'd0);
    chk("reset.id",    32'(resp_id),    32'd0);
    chk("reset.data",  32'(resp_data),  32'd0);
    chk("reset.err",   32'(resp_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // backpressure: hold result 5 cycles, then drain+accept in the same cycle
    apply_vec(mk(1,0,'h00A5,4, 0,0,0,0, 0, 1,0, 1,0,'h0A50,0), "bp.first");
    for (int i = 0; i < 5; i++)
      apply_vec(mk(1,0,'h0003,1, 1,2,'h0001,1, 0, 0,0, 1,0,'h0A50,0), $sformatf("bp.stall%0d", i));
    apply_vec(mk(1,0,'h0003,1, 1,2,'h0001,1, 1, 0,1, 1,1,'h8000,0), "bp.release");
    apply_vec(mk(1,0,'h0003,1, 0,0,0,0,      1, 1,0, 1,0,'h0006,0), "bp.next");

    // req1 streaming rotates of 0x8001
    for (int k = 1; k < 16; k++)
      apply_vec(mk(0,0,0,0, 1,2,'h8001,k, 1, 0,1, 1,1, (1 << (16-k)) | (1 << (15-k)), 0),
                $sformatf("stream.amt%0d", k));
    apply_vec(mk(0,0,0,0, 0,0,0,0, 1, 0,0, 0,1,'h0003,0), "stream.drain");

    // reset while a result is pending and a contention is waiting
    apply_vec(mk(1,3,'h1234,8, 0,0,0,0, 0, 1,0, 1,0,'h1234,1), "rst.pend");
    @(negedge clk);
    rst = 1'b1;
    drive(1, 2'd0, 16'h0001, 4'd1, 1, 2'd0, 16'h0001, 4'd2, 0);
    #1;
    chk("rst.rdy0", 32'(req0_ready), 32'd0);
    chk("rst.rdy1", 32'(req1_ready), 32'd0);
    tick();
    chk("rst.valid", 32'(resp_valid), 32'd0);
    chk("rst.data",  32'(resp_data),  32'd0);
    chk("rst.err",   32'(resp_err),   32'd0);
    chk("rst.busy",  32'(busy),       32'd0);
    rst = 1'b0;
    apply_vec(mk(1,0,'h0001,1, 1,0,'h0001,2, 1, 1,0, 1,0,'h0002,0), "rst.first");
    apply_vec(mk(0,0,0,0,      1,0,'h0001,2, 1, 0,1, 1,1,'h0004,0), "rst.second");
    apply_vec(mk(0,0,0,0,      0,0,0,0,      1, 0,0, 0,1,'h0004,0), "rst.idle");

    // random soak against a reference model and per-requester scoreboards
    m_valid = 1'b0; m_id = 1'b1; m_last = 1'b1;
    for (int c = 0; c < 2020; c++) begin
      s_gen = (c < 2000);
      @(negedge clk);
      if (!h_p0) begin
        s_v0 = s_gen && ($urandom_range(0, 3) != 0);
        s_op0 = 2'($urandom_range(0, 3)); s_d0 = 16'($urandom); s_a0 = 4'($urandom_range(0, 15));
      end
      if (!h_p1) begin
        s_v1 = s_gen && ($urandom_range(0, 3) != 0);
        s_op1 = 2'($urandom_range(0, 3)); s_d1 = 16'($urandom); s_a1 = 4'($urandom_range(0, 15));
      end
      s_rr = !s_gen || ($urandom_range(0, 3) != 0);
      drive(s_v0, s_op0, s_d0, s_a0, s_v1, s_op1, s_d1, s_a1, s_rr);
      #1;
      s_ca = !m_valid | s_rr;
      s_g0 = s_v0 & (!s_v1 | m_last);
      s_g1 = s_v1 & (!s_v0 | !m_last);
      chk("soak.both_rdy", 32'(req0_ready & req1_ready), 32'd0);
      chk("soak.rdy0", 32'(req0_ready), 32'(s_ca & s_g0));
      chk("soak.rdy1", 32'(req1_ready), 32'(s_ca & s_g1));
      chk("soak.valid", 32'(resp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("soak.id", 32'(resp_id), 32'(m_id));
        if (s_rr) begin
          if (m_id == 1'b0) begin
            chk("soak.q0_nonempty", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
              s_exp = q0.pop_front();
              chk("soak.resp0", 32'({resp_err, resp_data}), 32'(s_exp));
            end
          end else begin
            chk("soak.q1_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
              s_exp = q1.pop_front();
              chk("soak.resp1", 32'({resp_err, resp_data}), 32'(s_exp));
            end
          end
        end
      end
      s_acc0 = s_ca & s_g0;
      s_acc1 = s_ca & s_g1;
      if (s_acc0) q0.push_back(ref_f(s_op0, s_d0, s_a0));
      if (s_acc1) q1.push_back(ref_f(s_op1, s_d1, s_a1));
      if (s_acc0 | s_acc1) begin
        m_valid = 1'b1;
        m_id    = s_acc1;
        m_last  = s_acc1;
      end else if (s_rr) begin
        m_valid = 1'b0;
      end
      tick();
    end
    chk("soak.q0_empty", 32'(q0.size()), 32'd0);
    chk("soak.q1_empty", 32'(q1.size()), 32'd0);
    chk("soak.end_valid", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
